// File: rtl/fpu_pipe_pkg.sv
// Shared types and constants for the FPU op/XADD delay line beside the H/L FPU halves.
package fpu_pipe_pkg;

  localparam int unsigned FPU_OPW   = 21;
  localparam int unsigned ERR_CNT_W = 4;

  // fop_cmpDH encoding from fpoperations: its flags are produced by the H half.
  localparam logic [7:0] FOP_CMP_DH = 8'h3b;

  typedef struct packed {
    logic               vld;
    logic [FPU_OPW-1:0] op;
    logic               xadd;
  } fpu_stage_t;

endpackage

// File: rtl/fpu_opq_lane.sv
// One FPU issue port: DEPTH-stage op/XADD shift register with its cross-add,
// flag-select and busy taps.
module fpu_opq_lane
  import fpu_pipe_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OPW      = FPU_OPW,
  parameter int unsigned FLW      = 6,
  parameter int unsigned XADD_BIT = 10,
  parameter logic [7:0]  CMP_OP   = FOP_CMP_DH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_stall,
  input  logic           i_flush,
  input  logic           i_vld,
  input  logic [OPW-1:0] i_op,
  input  logic           i_xadd,
  input  logic [FLW-1:0] i_foos_h,
  input  logic [FLW-1:0] i_foos_l,
  output logic           o_xadd_vec,
  output logic [FLW-1:0] o_fus,
  output logic           o_busy
);

  fpu_stage_t r_stage [DEPTH];
  fpu_stage_t w_in;
  fpu_stage_t w_xtap;
  fpu_stage_t w_ftap;

  always_comb begin
    w_in      = '0;
    w_in.vld  = i_vld;
    w_in.op   = FPU_OPW'(i_op);
    w_in.xadd = i_xadd;
  end

  // Flush wins over stall; bubbles carry their op/xadd contents forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (!i_stall) begin
      r_stage[0] <= w_in;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign w_xtap = r_stage[DEPTH-2];
  assign w_ftap = r_stage[DEPTH-1];

  assign o_xadd_vec = w_xtap.vld & ~w_xtap.xadd & w_xtap.op[XADD_BIT];

  always_comb begin
    o_fus = i_foos_l;
    if (w_ftap.vld && (w_ftap.op[7:0] == CMP_OP)) o_fus = i_foos_h;
  end

  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) o_busy = o_busy | r_stage[k].vld;
  end

endmodule

// File: rtl/fpu_opq_pipe.sv
// Multi-port FPU op/XADD delay line with H/L return-tag merge and sticky
// double-drive collision tracking.
module fpu_opq_pipe
  import fpu_pipe_pkg::*;
#(
  parameter int unsigned PORTS    = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OPW      = FPU_OPW,
  parameter int unsigned FLW      = 6,
  parameter int unsigned RETW     = 14,
  parameter int unsigned XADD_BIT = 10,
  parameter logic [7:0]  CMP_OP   = FOP_CMP_DH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PORTS-1:0]      in_vld,
  input  logic [PORTS*OPW-1:0]  in_op,
  input  logic [PORTS-1:0]      in_xadd,
  input  logic [PORTS*RETW-1:0] retH,
  input  logic [PORTS*RETW-1:0] retL,
  input  logic [PORTS-1:0]      ret_enH,
  input  logic [PORTS-1:0]      ret_enL,
  input  logic [PORTS*FLW-1:0]  foosH,
  input  logic [PORTS*FLW-1:0]  foosL,
  output logic [PORTS-1:0]      xadd_vec,
  output logic [PORTS*FLW-1:0]  fus,
  output logic [PORTS*RETW-1:0] ret,
  output logic [PORTS-1:0]      ret_en,
  output logic [PORTS-1:0]      busy,
  output logic                  ret_err,
  output logic [ERR_CNT_W-1:0]  ret_err_cnt
);

  logic                 w_coll;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    fpu_opq_lane #(
      .DEPTH    (DEPTH),
      .OPW      (OPW),
      .FLW      (FLW),
      .XADD_BIT (XADD_BIT),
      .CMP_OP   (CMP_OP)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_stall    (stall),
      .i_flush    (flush),
      .i_vld      (in_vld[p]),
      .i_op       (in_op[p*OPW +: OPW]),
      .i_xadd     (in_xadd[p]),
      .i_foos_h   (foosH[p*FLW +: FLW]),
      .i_foos_l   (foosL[p*FLW +: FLW]),
      .o_xadd_vec (xadd_vec[p]),
      .o_fus      (fus[p*FLW +: FLW]),
      .o_busy     (busy[p])
    );
  end

  // Return path is pure merge: both halves never legally drive the same port.
  assign ret    = retH | retL;
  assign ret_en = ret_enH | ret_enL;
  assign w_coll = |(ret_enH & ret_enL);

  // One count per colliding cycle, however many ports collided.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_coll) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign ret_err     = r_err;
  assign ret_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fpu_opq_pipe.sv
// Scoreboard bench for fpu_opq_pipe: default build plus PORTS=1/DEPTH=2 and PORTS=4/DEPTH=8 builds.
`timescale 1ns/1ps
module tb_fpu_opq_pipe;
  import fpu_pipe_pkg::*;

  localparam int P = 3, OPW = 21, FLW = 6, RETW = 14;
  localparam logic [7:0] CMP = FOP_CMP_DH;
  typedef logic [P*RETW-1:0] retv_t;
  typedef logic [P*FLW-1:0]  flgv_t;

  logic clk = 0, rst = 1, stall = 0, flush = 0;
  logic [P-1:0] in_vld = '0, in_xadd = '0, ret_enH = '0, ret_enL = '0;
  logic [P*OPW-1:0] in_op = '0;
  retv_t retH = '0, retL = '0, ret;
  flgv_t foosH = '0, foosL = '0, fus;
  logic [P-1:0] xadd_vec, ret_en, busy;
  logic ret_err;
  logic [3:0] ret_err_cnt;

  // PORTS=1, DEPTH=2 build
  logic a_vld = 0, a_xadd = 0, a_xv, a_busy, a_en, a_err;
  logic [OPW-1:0] a_op = '0;
  logic [FLW-1:0] a_fh = '0, a_fl = '0, a_fus;
  logic [RETW-1:0] a_ret;
  logic [3:0] a_cnt;
  // PORTS=4, DEPTH=8 build
  logic [3:0] b_vld = '0, b_xadd = '0, b_xv, b_busy, b_en;
  logic [4*OPW-1:0] b_op = '0;
  logic [4*FLW-1:0] b_fh = '0, b_fl = '0, b_fus;
  logic [4*RETW-1:0] b_ret;
  logic b_err;
  logic [3:0] b_cnt;

  int n_run = 0, n_fail = 0, cyc = 0;
  bit sb_on = 0;

  typedef struct {int c; logic [P-1:0] xm; logic [P-1:0] hm;} exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_opq_pipe u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_vld(in_vld), .in_op(in_op),
    .in_xadd(in_xadd), .retH(retH), .retL(retL), .ret_enH(ret_enH), .ret_enL(ret_enL),
    .foosH(foosH), .foosL(foosL), .xadd_vec(xadd_vec), .fus(fus), .ret(ret), .ret_en(ret_en),
    .busy(busy), .ret_err(ret_err), .ret_err_cnt(ret_err_cnt)
  );

  fpu_opq_pipe #(.PORTS(1), .DEPTH(2)) u_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_vld(a_vld), .in_op(a_op),
    .in_xadd(a_xadd), .retH('0), .retL('0), .ret_enH(1'b0), .ret_enL(1'b0),
    .foosH(a_fh), .foosL(a_fl), .xadd_vec(a_xv), .fus(a_fus), .ret(a_ret), .ret_en(a_en),
    .busy(a_busy), .ret_err(a_err), .ret_err_cnt(a_cnt)
  );

  fpu_opq_pipe #(.PORTS(4), .DEPTH(8)) u_big (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_vld(b_vld), .in_op(b_op),
    .in_xadd(b_xadd), .retH('0), .retL('0), .ret_enH(4'b0), .ret_enL(4'b0),
    .foosH(b_fh), .foosL(b_fl), .xadd_vec(b_xv), .fus(b_fus), .ret(b_ret), .ret_en(b_en),
    .busy(b_busy), .ret_err(b_err), .ret_err_cnt(b_cnt)
  );

  function automatic logic [OPW-1:0] mkop(input logic xr, input logic cmp);
    logic [OPW-1:0] o;
    o = '0;
    o[10] = xr;
    o[7:0] = cmp ? CMP : 8'h01;
    return o;
  endfunction

  task automatic push(input int c, input logic [P-1:0] xm, input logic [P-1:0] hm);
    exp_t e;
    e.c = c; e.xm = xm; e.hm = hm;
    sb_q.push_back(e);
  endtask

  task automatic nxt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every cycle: pop expectations due now; anything not expected must read as idle.
  always @(negedge clk) begin : mon
    logic [P-1:0] ex, eh;
    flgv_t ef;
    if (sb_on) begin
      ex = '0; eh = '0;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].c == cyc) begin
          ex |= sb_q[i].xm; eh |= sb_q[i].hm;
          sb_q.delete(i);
        end
      end
      for (int p = 0; p < P; p++)
        ef[p*FLW +: FLW] = eh[p] ? foosH[p*FLW +: FLW] : foosL[p*FLW +: FLW];
      n_run += 2;
      if (xadd_vec !== ex) begin
        n_fail++; $display("FAIL sb_xadd cyc=%0d got=%b exp=%b", cyc, xadd_vec, ex);
      end
      if (fus !== ef) begin
        n_fail++; $display("FAIL sb_fus cyc=%0d got=%h exp=%h", cyc, fus, ef);
      end
    end
  end

  task automatic test_reset();
    sb_on = 0;
    #1 rst = 0;
    #1; n_run += 3;
    if (busy !== '0) begin n_fail++; $display("FAIL rst0_busy got=%b exp=0", busy); end
    if (xadd_vec !== '0) begin n_fail++; $display("FAIL rst0_xadd got=%b exp=0", xadd_vec); end
    if (ret_err !== 1'b0 || ret_err_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst0_err got=%b/%0d exp=0/0", ret_err, ret_err_cnt);
    end
    @(negedge clk) rst = 1;
    nxt(1);
    in_vld = '1; in_xadd = '0; ret_enH = 3'b001; ret_enL = 3'b001;
    for (int p = 0; p < P; p++) in_op[p*OPW +: OPW] = mkop(1'b1, 1'b1);
    nxt(4);
    in_vld = '0; ret_enH = '0; ret_enL = '0;
    foosH = flgv_t'($urandom()); foosL = flgv_t'($urandom());
    retH = retv_t'({$urandom(), $urandom()}); retL = retv_t'({$urandom(), $urandom()});
    #1; n_run += 2;
    if (xadd_vec !== 3'b111) begin n_fail++; $display("FAIL fill_xadd got=%b exp=111", xadd_vec); end
    if (ret_err_cnt !== 4'd4) begin n_fail++; $display("FAIL fill_cnt got=%0d exp=4", ret_err_cnt); end
    rst = 0;
    #1; n_run += 6;
    if (busy !== '0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (xadd_vec !== '0) begin n_fail++; $display("FAIL rst_xadd got=%b exp=0", xadd_vec); end
    if (ret_err_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", ret_err_cnt); end
    if (ret_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", ret_err); end
    if (fus !== foosL) begin n_fail++; $display("FAIL rst_fus got=%h exp=%h", fus, foosL); end
    if (ret !== (retH | retL)) begin
      n_fail++; $display("FAIL rst_ret got=%h exp=%h", ret, retH | retL);
    end
    @(negedge clk) rst = 1;
    nxt(1);
    sb_on = 1;
  endtask

  task automatic test_xadd();
    int c0;
    c0 = cyc;
    in_vld = 3'b001; in_xadd = 3'b000; in_op[0 +: OPW] = mkop(1'b1, 1'b0);
    push(c0 + 3, 3'b001, 3'b000);
    nxt(1);
    in_xadd = 3'b001;
    nxt(1);
    in_vld = '0; in_xadd = '0;
    nxt(6);
  endtask

  task automatic test_cmp_select();
    int c0;
    logic [FLW-1:0] e;
    foosH = {6'h2A, 12'($urandom())}; foosL = {6'h15, 12'($urandom())};
    c0 = cyc;
    in_vld = 3'b100; in_op[2*OPW +: OPW] = mkop(1'b0, 1'b1);
    push(c0 + 4, 3'b000, 3'b100);
    for (int n = 0; n <= 5; n++) begin
      #1; n_run++;
      e = (n == 4) ? 6'h2A : 6'h15;
      if (fus[2*FLW +: FLW] !== e) begin
        n_fail++; $display("FAIL cmp_fus cyc%0d got=%h exp=%h", n, fus[2*FLW +: FLW], e);
      end
      nxt(1);
      in_vld = '0;
    end
    nxt(2);
  endtask

  task automatic test_stall();
    int c0;
    c0 = cyc;
    in_vld = 3'b010; in_op[OPW +: OPW] = mkop(1'b1, 1'b1);
    push(c0 + 6, 3'b010, 3'b000);
    push(c0 + 7, 3'b000, 3'b010);
    nxt(1);
    stall = 1; in_vld = 3'b001; in_op[0 +: OPW] = mkop(1'b1, 1'b0);
    nxt(1);
    in_vld = '0;
    #1; n_run++;
    if (busy !== 3'b010) begin n_fail++; $display("FAIL stall_busy got=%b exp=010", busy); end
    nxt(2);
    stall = 0;
    nxt(8);
    // Stall while the op sits at the cross-add tap.
    c0 = cyc;
    in_vld = 3'b010;
    for (int k = 3; k <= 6; k++) push(c0 + k, 3'b010, 3'b000);
    push(c0 + 7, 3'b000, 3'b010);
    nxt(1);
    in_vld = '0;
    nxt(2);
    stall = 1;
    nxt(3);
    stall = 0;
    nxt(6);
  endtask

  task automatic test_flush();
    in_vld = 3'b010; in_op[OPW +: OPW] = mkop(1'b1, 1'b1);
    nxt(1);
    in_vld = '0; stall = 1;
    nxt(1);
    #1; n_run++;
    if (busy !== 3'b010) begin n_fail++; $display("FAIL preflush_busy got=%b exp=010", busy); end
    flush = 1;
    nxt(1);
    flush = 0;
    #1; n_run++;
    if (busy !== 3'b000) begin n_fail++; $display("FAIL flush_busy got=%b exp=000", busy); end
    nxt(1);
    stall = 0;
    nxt(6);
  endtask

  task automatic test_collision();
    int e;
    ret_enH = 3'b010; ret_enL = 3'b010;
    for (int n = 0; n < 20; n++) begin
      retH = retv_t'({$urandom(), $urandom()}); retL = retv_t'({$urandom(), $urandom()});
      #1; n_run += 4;
      e = (n > 15) ? 15 : n;
      if (ret !== (retH | retL)) begin
        n_fail++; $display("FAIL coll_ret n=%0d got=%h exp=%h", n, ret, retH | retL);
      end
      if (ret_en !== 3'b010) begin n_fail++; $display("FAIL coll_en got=%b exp=010", ret_en); end
      if (ret_err !== (n > 0)) begin
        n_fail++; $display("FAIL coll_err n=%0d got=%b exp=%b", n, ret_err, n > 0);
      end
      if (ret_err_cnt !== 4'(e)) begin
        n_fail++; $display("FAIL coll_cnt n=%0d got=%0d exp=%0d", n, ret_err_cnt, e);
      end
      nxt(1);
    end
    ret_enH = '0; ret_enL = '0; flush = 1;
    nxt(1);
    flush = 0;
    #1; n_run++;
    if (ret_err !== 1'b1 || ret_err_cnt !== 4'd15) begin
      n_fail++; $display("FAIL coll_hold got=%b/%0d exp=1/15", ret_err, ret_err_cnt);
    end
    nxt(1);
  endtask

  task automatic test_back_to_back();
    logic [P-1:0] v, xr, xq, cm;
    for (int n = 0; n < 12; n++) begin
      v = P'($urandom()); xr = P'($urandom()); xq = P'($urandom()); cm = P'($urandom());
      for (int p = 0; p < P; p++) in_op[p*OPW +: OPW] = mkop(xr[p], cm[p]);
      in_vld = v; in_xadd = xq;
      foosH = flgv_t'($urandom()); foosL = flgv_t'($urandom());
      push(cyc + 3, v & ~xq & xr, 3'b000);
      push(cyc + 4, 3'b000, v & cm);
      nxt(1);
    end
    in_vld = '0;
    for (int n = 0; n < 6; n++) begin
      foosH = flgv_t'($urandom()); foosL = flgv_t'($urandom());
      nxt(1);
    end
    n_run++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_sweep();
    logic [3:0] bx;
    a_fh = 6'h33; a_fl = 6'h0C; b_fh = 24'hA5C3F1; b_fl = 24'h1E2D3C;
    a_vld = 1; a_xadd = 0; a_op = mkop(1'b1, 1'b1);
    b_vld = 4'hF; b_xadd = 4'b1010;
    for (int p = 0; p < 4; p++) b_op[p*OPW +: OPW] = mkop(1'b1, 1'b1);
    for (int n = 0; n < 10; n++) begin
      #1; n_run += 6;
      bx = (n == 7) ? 4'b0101 : 4'b0000;
      if (a_xv !== (n == 1)) begin n_fail++; $display("FAIL s1_xadd c%0d got=%b", n, a_xv); end
      if (a_fus !== ((n == 2) ? a_fh : a_fl)) begin
        n_fail++; $display("FAIL s1_fus c%0d got=%h", n, a_fus);
      end
      if (a_busy !== (n == 1 || n == 2)) begin
        n_fail++; $display("FAIL s1_busy c%0d got=%b", n, a_busy);
      end
      if (b_xv !== bx) begin n_fail++; $display("FAIL s8_xadd c%0d got=%b exp=%b", n, b_xv, bx); end
      if (b_fus !== ((n == 8) ? b_fh : b_fl)) begin
        n_fail++; $display("FAIL s8_fus c%0d got=%h", n, b_fus);
      end
      if (b_busy !== ((n >= 1 && n <= 8) ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL s8_busy c%0d got=%b", n, b_busy);
      end
      nxt(1);
      a_vld = 0; b_vld = '0;
    end
  endtask

  initial begin
    test_reset();
    test_xadd();
    test_cmp_select();
    test_stall();
    test_flush();
    test_collision();
    test_back_to_back();
    test_sweep();
    sb_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpu_opq_pipe.md
Name: fpu_opq_pipe

Overview:
- Parametrised successor to the fixed three-port FPU op/XADD delay line that sits beside the H/L FPU halves.
- Carries per-port op code, XADD flag and a valid bit through a DEPTH-stage pipeline, with stall and flush.
- Produces the cross-add enable vector for the last-but-one stage and selects the H- or L-half flag bus for compare-high ops at the last stage.
- Merges H/L return tags and detects double-drive collisions.

Parameters:
PORTS, 3, number of FPU issue ports
DEPTH, 4, pipeline stages (legal range 2..8)
OPW, 21, op code width
FLW, 6, flag/status bus width per port
RETW, 14, return tag width per port
XADD_BIT, 10, op bit that requests cross-half add
CMP_OP, `fop_cmpDH, 8-bit op code whose flags come from the H half

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stall  in  1  hold every stage; no capture
flush  in  1  invalidate every stage
in_vld  in  PORTS  op issued on port p
in_op  in  PORTS*OPW  op code, port p at [p*OPW +: OPW]
in_xadd  in  PORTS  XADD qualifier per port
retH  in  PORTS*RETW  H-half return tag
retL  in  PORTS*RETW  L-half return tag
ret_enH  in  PORTS  H-half return valid
ret_enL  in  PORTS  L-half return valid
foosH  in  PORTS*FLW  H-half flags
foosL  in  PORTS*FLW  L-half flags
xadd_vec  out  PORTS  cross-add enables, broadcast to both halves
fus  out  PORTS*FLW  selected flags
ret  out  PORTS*RETW  merged return tag
ret_en  out  PORTS  merged return valid
busy  out  PORTS  any stage of port p valid
ret_err  out  1  sticky collision flag
ret_err_cnt  out  4  saturating collision count

Behaviour:
Reset (rst=0, asynchronous):
- All stage vld, op and xadd bits clear to 0.
- ret_err=0, ret_err_cnt=0.
- Outputs therefore reset to: xadd_vec=0, busy=0, fus=foosL, ret=retH|retL, ret_en=ret_enH|ret_enL.

Per port p, stage registers s[1..DEPTH], each holding {vld, op, xadd}:
- Capture edge with flush=1: every vld clears to 0. op/xadd bits are don't-care but must be zeroed. Flush overrides stall.
- Capture edge with stall=1 and flush=0: all stages hold.
- Otherwise:
  - s[1] <= {in_vld, in_op, in_xadd}
  - s[k] <= s[k-1] for k = 2..DEPTH
- op and xadd advance even when vld=0 (the bubble carries its contents).

Outputs:
- xadd_vec[p] = s[DEPTH-1].vld & ~s[DEPTH-1].xadd & s[DEPTH-1].op[XADD_BIT]. Combinational from registers, i.e. DEPTH-1 cycles after issue.
- fus[p] = foosH[p] when s[DEPTH].vld and s[DEPTH].op[7:0]==CMP_OP; otherwise foosL[p]. DEPTH cycles after issue.
- busy[p] = OR over k of s[k].vld.
- ret[p] = retH[p] | retL[p]; ret_en[p] = ret_enH[p] | ret_enL[p]. Combinational, zero latency, unaffected by stall and flush.

Collision detection:
- A collision is ret_enH[p] & ret_enL[p] for any p in a cycle.
- On each such cycle: ret_err <= 1, and ret_err_cnt increments by 1 regardless of how many ports collided, saturating at 15.
- Both are cleared only by reset; flush does not clear them.

Boundaries:
- DEPTH=2: xadd_vec is taken from s[1].
- A stall lasting any number of cycles holds xadd_vec and fus selection constant.
- Stall and in_vld in the same cycle: the input is dropped. The issuer must hold in_vld across stall.

Decomposition:
- Shared package fpu_pipe_pkg holds:
  - the stage struct {vld, op[OPW], xadd}
  - the CMP_OP default, taken from fpoperations
  - ERR_CNT_W=4
- One sub-module, fpu_opq_lane, is one port's DEPTH-stage shift register plus its xadd/fus/busy logic.
- The top instantiates PORTS lanes and the shared collision counter.

Test Plan:
- Reset: assert rst=0 mid-stream with stages full -> within the same cycle busy=0, xadd_vec=0, ret_err_cnt=0, fus=foosL.
- Cross-add timing: DEPTH=4, port0 in_vld=1, op[10]=1, xadd=0 at cycle 0 -> xadd_vec=3'b001 in cycle 3 only. Same op with xadd=1 -> xadd_vec stays 0.
- Compare-high select: port2 op[7:0]=CMP_OP, foosH=6'h2A, foosL=6'h15 -> fus port2 = 6'h15 in cycles 0..3, 6'h2A in cycle 4, 6'h15 in cycle 5.
- Stall then flush: issue on port1, stall 3 cycles from cycle 1 -> xadd_vec asserts at cycle 6. Flush at cycle 2 with stall still high -> busy[1]=0 from cycle 3 and xadd_vec never asserts.
- Collision: ret_enH=ret_enL=3'b010 for 20 cycles -> ret_err=1 after the first edge; ret_err_cnt saturates at 15; ret[1]=retH|retL each cycle.
- Parameter sweep: PORTS=1, DEPTH=2 and PORTS=4, DEPTH=8 -> xadd latency DEPTH-1 and flag latency DEPTH on every port.
